// File: rtl/hqs_pkg.sv
// Shared constants and FSM encoding for the host queue scheduler.
// No ports; imported by hqs_rr_arbiter, host_queue_scheduler_if and host_queue_scheduler.
package hqs_pkg;

    localparam int TS_FLOW_NUM  = 32;
    localparam int PTR_W        = 5;
    localparam int DESC_W       = 13;
    localparam int BUFID_W      = 9;
    localparam int STARVE_LIMIT = 8;

    // Inport tag marking a TS-overflow entry in the NTS FIFO: it is freed, never forwarded.
    localparam logic [3:0] DISCARD_INPORT = 4'hf;

    // state    | meaning
    // ST_IDLE  | arbitrate TS bitmap / NTS FIFO, register read strobe on grant
    // ST_RD    | read strobe high this cycle, rr pointer advances on TS grant
    // ST_CAP   | capture RAM/FIFO data, route to HOI or to buffer-free path
    // ST_OUT   | hold descriptor valid until HOI ready
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_OUT  = 2'd3
    } hqs_state_e;

endpackage

// File: rtl/host_queue_scheduler_if.sv
// Descriptor handshake towards the host output interface (HOI).
// Signals:
//   descriptor        13  descriptor {inport[3:0],bufid[8:0]}
//   descriptor_wr     1   descriptor valid, held until descriptor_ready is seen
//   descriptor_ready  1   HOI accepts the descriptor this cycle
// master: scheduler side; slave: HOI side.
interface host_queue_scheduler_if;
    import hqs_pkg::*;

    logic [DESC_W-1:0] descriptor;
    logic              descriptor_wr;
    logic              descriptor_ready;

    modport master (
        output descriptor,
        output descriptor_wr,
        input  descriptor_ready
    );

    modport slave (
        input  descriptor,
        input  descriptor_wr,
        output descriptor_ready
    );

endinterface

// File: rtl/hqs_rr_arbiter.sv
// Combinational round-robin pick over the TS occupancy bitmap.
// Ports:
//   req_i        in   32  occupancy bitmap (request per slot)
//   ptr_i        in   5   round-robin pointer, search starts here
//   gnt_valid_o  out  1   any request present
//   gnt_idx_o    out  5   lowest set index >= ptr_i, else lowest set index (wrap)
module hqs_rr_arbiter
    import hqs_pkg::*;
(
    input  logic [TS_FLOW_NUM-1:0] req_i,
    input  logic [PTR_W-1:0]       ptr_i,
    output logic                   gnt_valid_o,
    output logic [PTR_W-1:0]       gnt_idx_o
);

    logic [TS_FLOW_NUM-1:0] upper;
    logic                   hi_found;
    logic                   lo_found;
    logic [PTR_W-1:0]       hi_idx;
    logic [PTR_W-1:0]       lo_idx;

    always_comb begin
        // requests at or above the pointer; if none, fall back to the whole vector
        upper    = req_i & ~((TS_FLOW_NUM'(1) << ptr_i) - TS_FLOW_NUM'(1));
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = TS_FLOW_NUM - 1; i >= 0; i--) begin
            if (upper[i]) begin
                hi_found = 1'b1;
                hi_idx   = PTR_W'(i);
            end
            if (req_i[i]) begin
                lo_found = 1'b1;
                lo_idx   = PTR_W'(i);
            end
        end
        gnt_valid_o = lo_found;
        gnt_idx_o   = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/host_queue_scheduler.sv
// Host queue scheduler: tracks TS descriptor slot occupancy, drains TS slots (round-robin,
// priority) and the NTS FIFO one descriptor at a time to the HOI; overflow-tagged NTS
// entries are returned to the buffer-free path instead.
// Optional feature macro: HQS_STARVE_GUARD_EN (forces an NTS grant after STARVE_LIMIT
// consecutive TS grants made while the NTS FIFO is non-empty).
// Ports:
//   i_clk, i_rst_n               clock, async active-low reset
//   i_ts_descriptor_wr/_waddr    input-stage TS slot write (sets occupancy bit)
//   ov_ts_cnt                    32-bit slot occupancy bitmap
//   o_ts_descriptor_rd/_raddr    TS RAM read strobe/address; iv_ts_descriptor_rdata 1 cycle later
//   i_nts_fifo_empty, o_nts_fifo_rd, iv_nts_fifo_rdata   NTS FIFO pop interface
//   hoi                          descriptor handshake to HOI (master modport)
//   ov_free_bufid, o_free_bufid_wr                       buffer-free strobe
module host_queue_scheduler
    import hqs_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_ts_descriptor_wr,
    input  logic [PTR_W-1:0]       iv_ts_descriptor_waddr,
    output logic [TS_FLOW_NUM-1:0] ov_ts_cnt,
    output logic                   o_ts_descriptor_rd,
    output logic [PTR_W-1:0]       ov_ts_descriptor_raddr,
    input  logic [DESC_W-1:0]      iv_ts_descriptor_rdata,
    input  logic                   i_nts_fifo_empty,
    output logic                   o_nts_fifo_rd,
    input  logic [DESC_W-1:0]      iv_nts_fifo_rdata,
    host_queue_scheduler_if.master hoi,
    output logic [BUFID_W-1:0]     ov_free_bufid,
    output logic                   o_free_bufid_wr
);

    hqs_state_e             state_q;
    logic [TS_FLOW_NUM-1:0] ts_cnt_q, ts_cnt_d;
    logic [PTR_W-1:0]       rr_ptr_q;
    logic [PTR_W-1:0]       raddr_q;
    logic                   sel_ts_q;
    logic                   ts_rd_q;
    logic                   nts_rd_q;
    logic [DESC_W-1:0]      desc_q;
    logic                   desc_wr_q;
    logic [BUFID_W-1:0]     free_bufid_q;
    logic                   free_wr_q;

    logic                   gnt_valid;
    logic [PTR_W-1:0]       gnt_idx;
    logic                   take_nts;
    logic [DESC_W-1:0]      cap_data;

    hqs_rr_arbiter u_rr_arbiter (
        .req_i       (ts_cnt_q),
        .ptr_i       (rr_ptr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

`ifdef HQS_STARVE_GUARD_EN
    logic [3:0] starve_q;
    assign take_nts = !i_nts_fifo_empty && (!gnt_valid || (starve_q >= 4'(STARVE_LIMIT)));
`else
    assign take_nts = !i_nts_fifo_empty && !gnt_valid;
`endif

    assign cap_data = sel_ts_q ? iv_ts_descriptor_rdata : iv_nts_fifo_rdata;

    // Clear lands in the strobe cycle; a same-cycle write to that slot is applied
    // afterwards so the new descriptor is not lost (set wins).
    always_comb begin
        ts_cnt_d = ts_cnt_q;
        if (state_q == ST_RD && sel_ts_q) begin
            ts_cnt_d[raddr_q] = 1'b0;
        end
        if (i_ts_descriptor_wr) begin
            ts_cnt_d[iv_ts_descriptor_waddr] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ts_cnt_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            raddr_q      <= '0;
            sel_ts_q     <= 1'b0;
            ts_rd_q      <= 1'b0;
            nts_rd_q     <= 1'b0;
            desc_q       <= '0;
            desc_wr_q    <= 1'b0;
            free_bufid_q <= '0;
            free_wr_q    <= 1'b0;
`ifdef HQS_STARVE_GUARD_EN
            starve_q     <= '0;
`endif
        end else begin
            ts_rd_q   <= 1'b0;
            nts_rd_q  <= 1'b0;
            free_wr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (take_nts) begin
                        nts_rd_q <= 1'b1;
                        sel_ts_q <= 1'b0;
                        state_q  <= ST_RD;
`ifdef HQS_STARVE_GUARD_EN
                        starve_q <= '0;
`endif
                    end else if (gnt_valid) begin
                        ts_rd_q  <= 1'b1;
                        raddr_q  <= gnt_idx;
                        sel_ts_q <= 1'b1;
                        state_q  <= ST_RD;
`ifdef HQS_STARVE_GUARD_EN
                        // only TS grants that actually bypass waiting NTS traffic count
                        starve_q <= i_nts_fifo_empty ? '0 : starve_q + 4'd1;
`endif
                    end
                end
                ST_RD: begin
                    if (sel_ts_q) begin
                        rr_ptr_q <= raddr_q + 5'd1;
                    end
                    state_q <= ST_CAP;
                end
                ST_CAP: begin
                    if (!sel_ts_q && cap_data[DESC_W-1 -: 4] == DISCARD_INPORT) begin
                        free_bufid_q <= cap_data[BUFID_W-1:0];
                        free_wr_q    <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else begin
                        desc_q    <= cap_data;
                        desc_wr_q <= 1'b1;
                        state_q   <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (hoi.descriptor_ready) begin
                        desc_wr_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ov_ts_cnt              = ts_cnt_q;
    assign o_ts_descriptor_rd     = ts_rd_q;
    assign ov_ts_descriptor_raddr = raddr_q;
    assign o_nts_fifo_rd          = nts_rd_q;
    assign hoi.descriptor         = desc_q;
    assign hoi.descriptor_wr      = desc_wr_q;
    assign ov_free_bufid          = free_bufid_q;
    assign o_free_bufid_wr        = free_wr_q;

endmodule

// File: tb/tb_host_queue_scheduler.sv
module tb_host_queue_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ts_wr;
    logic [4:0]  ts_waddr;
    logic [31:0] ts_cnt;
    logic        ts_rd;
    logic [4:0]  ts_raddr;
    logic [12:0] ts_rdata;
    logic        nts_empty;
    logic        nts_rd;
    logic [12:0] nts_rdata;
    logic [8:0]  free_bufid;
    logic        free_wr;

    logic [12:0] ts_ram [32];
    logic [12:0] nts_mem [16];
    int          nts_wr_ptr = 0;
    int          nts_rd_ptr = 0;

    int n_cmp = 0;
    int n_err = 0;

    host_queue_scheduler_if hoi_if ();

    host_queue_scheduler dut (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_ts_descriptor_wr     (ts_wr),
        .iv_ts_descriptor_waddr (ts_waddr),
        .ov_ts_cnt              (ts_cnt),
        .o_ts_descriptor_rd     (ts_rd),
        .ov_ts_descriptor_raddr (ts_raddr),
        .iv_ts_descriptor_rdata (ts_rdata),
        .i_nts_fifo_empty       (nts_empty),
        .o_nts_fifo_rd          (nts_rd),
        .iv_nts_fifo_rdata      (nts_rdata),
        .hoi                    (hoi_if),
        .ov_free_bufid          (free_bufid),
        .o_free_bufid_wr        (free_wr)
    );

    always #5 clk = ~clk;

    // RAM and FIFO models: data appears one cycle after the strobe
    assign nts_empty = (nts_wr_ptr == nts_rd_ptr);

    always @(posedge clk) begin
        if (ts_rd) ts_rdata <= ts_ram[ts_raddr];
        if (nts_rd) begin
            nts_rdata  <= nts_mem[nts_rd_ptr % 16];
            nts_rd_ptr <= nts_rd_ptr + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic [12:0] d);
        nts_mem[nts_wr_ptr % 16] = d;
        nts_wr_ptr = nts_wr_ptr + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called in the cycle whose closing edge is the TS grant; HOI ready must be high.
    task automatic expect_ts(input string tag, input logic [4:0] addr, input logic [12:0] data,
                             input logic [31:0] cnt_after);
        step();
        check({tag, ".ts_rd"}, 32'(ts_rd), 32'd1);
        check({tag, ".raddr"}, 32'(ts_raddr), 32'(addr));
        check({tag, ".nts_rd"}, 32'(nts_rd), 32'd0);
        step();
        check({tag, ".ts_rd_off"}, 32'(ts_rd), 32'd0);
        check({tag, ".cnt"}, ts_cnt, cnt_after);
        step();
        check({tag, ".wr"}, 32'(hoi_if.descriptor_wr), 32'd1);
        check({tag, ".desc"}, 32'(hoi_if.descriptor), 32'(data));
        step();
        check({tag, ".wr_off"}, 32'(hoi_if.descriptor_wr), 32'd0);
    endtask

    initial begin
        int ts_seen;
        bit got_nts;
        bit drained;

        rst_n    = 1'b0;
        ts_wr    = 1'b0;
        ts_waddr = '0;
        hoi_if.descriptor_ready = 1'b0;
        for (int i = 0; i < 32; i++) ts_ram[i] = 13'h200 + 13'(i);

        // reset state
        repeat (3) step();
        check("rst.cnt", ts_cnt, 32'h0);
        check("rst.desc_wr", 32'(hoi_if.descriptor_wr), 32'd0);
        check("rst.desc", 32'(hoi_if.descriptor), 32'd0);
        check("rst.ts_rd", 32'(ts_rd), 32'd0);
        check("rst.raddr", 32'(ts_raddr), 32'd0);
        check("rst.nts_rd", 32'(nts_rd), 32'd0);
        check("rst.free_wr", 32'(free_wr), 32'd0);
        check("rst.free_bufid", 32'(free_bufid), 32'd0);
        rst_n = 1'b1;
        step();

        // T2: NTS forwarded, descriptor valid at A+3 for one cycle
        hoi_if.descriptor_ready = 1'b1;
        push(13'h061A);
        step();
        check("T2.nts_rd", 32'(nts_rd), 32'd1);
        step();
        check("T2.nts_rd_off", 32'(nts_rd), 32'd0);
        check("T2.wr_early", 32'(hoi_if.descriptor_wr), 32'd0);
        step();
        check("T2.wr", 32'(hoi_if.descriptor_wr), 32'd1);
        check("T2.desc", 32'(hoi_if.descriptor), 32'h061A);
        step();
        check("T2.wr_off", 32'(hoi_if.descriptor_wr), 32'd0);

        // T3: overflow-tagged NTS goes to free path
        push(13'h1E55);
        step();
        check("T3.nts_rd", 32'(nts_rd), 32'd1);
        step();
        check("T3.free_early", 32'(free_wr), 32'd0);
        step();
        check("T3.free_wr", 32'(free_wr), 32'd1);
        check("T3.free_bufid", 32'(free_bufid), 32'h055);
        check("T3.no_desc", 32'(hoi_if.descriptor_wr), 32'd0);
        step();
        check("T3.free_off", 32'(free_wr), 32'd0);
        check("T3.no_desc2", 32'(hoi_if.descriptor_wr), 32'd0);

        // T4 + T1: HOI stalls 10 cycles while slots 5 then 2 are written
        hoi_if.descriptor_ready = 1'b0;
        push(13'h0123);
        step();
        check("T4.nts_rd", 32'(nts_rd), 32'd1);
        step();
        step();
        for (int k = 0; k < 10; k++) begin
            check("T4.wr_hold", 32'(hoi_if.descriptor_wr), 32'd1);
            check("T4.desc_hold", 32'(hoi_if.descriptor), 32'h0123);
            check("T4.no_ts_rd", 32'(ts_rd), 32'd0);
            check("T4.no_nts_rd", 32'(nts_rd), 32'd0);
            if (k == 1) check("T1.cnt_20", ts_cnt, 32'h20);
            if (k >= 2) check("T1.cnt_24", ts_cnt, 32'h24);
            if (k == 0) begin
                ts_wr = 1'b1;
                ts_waddr = 5'd5;
            end else if (k == 1) begin
                ts_waddr = 5'd2;
            end else begin
                ts_wr = 1'b0;
            end
            if (k < 9) step();
        end
        hoi_if.descriptor_ready = 1'b1;
        step();
        check("T4.wr_release", 32'(hoi_if.descriptor_wr), 32'd0);
        expect_ts("T1a", 5'd2, 13'h202, 32'h20);
        expect_ts("T1b", 5'd5, 13'h205, 32'h0);

        // T5: rewrite slot 7 in its strobe cycle; pointer is 6
        ts_wr = 1'b1;
        ts_waddr = 5'd7;
        step();
        ts_wr = 1'b0;
        check("T5.cnt_set", ts_cnt, 32'h80);
        step();
        check("T5.ts_rd", 32'(ts_rd), 32'd1);
        check("T5.raddr", 32'(ts_raddr), 32'd7);
        ts_wr = 1'b1;
        ts_waddr = 5'd7;
        step();
        ts_wr = 1'b0;
        check("T5.set_wins", ts_cnt, 32'h80);
        step();
        check("T5.wr", 32'(hoi_if.descriptor_wr), 32'd1);
        check("T5.desc", 32'(hoi_if.descriptor), 32'h207);
        step();
        check("T5.wr_off", 32'(hoi_if.descriptor_wr), 32'd0);
        // pointer now 8: search wraps back to slot 7
        expect_ts("T5b", 5'd7, 13'h207, 32'h0);

        // T6: all slots full with NTS waiting
        hoi_if.descriptor_ready = 1'b0;
        push(13'h0111);
        step();
        check("T6.nts_rd", 32'(nts_rd), 32'd1);
        step();
        step();
        check("T6.hold", 32'(hoi_if.descriptor_wr), 32'd1);
        for (int i = 0; i < 32; i++) begin
            ts_wr = 1'b1;
            ts_waddr = 5'(i);
            step();
        end
        ts_wr = 1'b0;
        check("T6.cnt_full", ts_cnt, 32'hFFFF_FFFF);
        push(13'h0222);
        hoi_if.descriptor_ready = 1'b1;
        ts_seen = 0;
        got_nts = 1'b0;
        for (int c = 0; c < 400 && !got_nts; c++) begin
            step();
            if (nts_rd) got_nts = 1'b1;
            else if (ts_rd) ts_seen++;
        end
        check("T6.nts_granted", 32'(got_nts), 32'd1);
`ifdef HQS_STARVE_GUARD_EN
        check("T6.ts_before_nts", 32'(ts_seen), 32'd8);
`else
        check("T6.ts_before_nts", 32'(ts_seen), 32'd32);
`endif
        step();
        step();
        check("T6.nts_desc", 32'(hoi_if.descriptor), 32'h0222);
        drained = 1'b0;
        for (int c = 0; c < 400 && !drained; c++) begin
            step();
            if (ts_cnt == 32'h0 && !hoi_if.descriptor_wr) drained = 1'b1;
        end
        check("T6.drained", 32'(drained), 32'd1);
        repeat (4) step();
        check("T6.idle_wr", 32'(hoi_if.descriptor_wr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
